// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives PS2Clk/PS2Data open-drain through active-high output enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s1_d;
    logic          clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d;
    logic          dat_s2_q, dat_s2_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          clk_flt_q, clk_flt_d;
    logic          fall_q, fall_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [TW-1:0] to_next;
    logic          timed;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    // Synchronize both pins and debounce the clock into a one-cycle fall strobe.
    always_comb begin
        clk_s1_d  = PS2Clk;
        clk_s2_d  = clk_s1_q;
        dat_s1_d  = PS2Data;
        dat_s2_d  = dat_s1_q;
        clk_flt_d = clk_flt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != clk_flt_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                clk_flt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
        fall_d = clk_flt_q & ~clk_flt_d;
    end

    // Conditioning registers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            clk_flt_q <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            clk_flt_q <= clk_flt_d;
            flt_cnt_q <= flt_cnt_d;
            fall_q    <= fall_d;
        end
    end

    // Request/frame sequencer with a watchdog that resets on every clock fall.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        to_next   = to_cnt_q + TW'(1);
        timed     = (state_q == S_BITS) || (state_q == S_ACK) ||
                    (state_q == S_WAIT_IDLE);
        unique case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_start) begin
                    shift_d   = {~^tx_data, tx_data};
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + IW'(1);
                end
            end
            S_REQ: begin
                clk_oe_d  = 1'b0;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                state_d   = S_BITS;
            end
            S_BITS: begin
                if (fall_q) begin
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_ACK: begin
                if (fall_q) begin
                    if (!dat_s2_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_flt_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timed) begin
            to_cnt_d = fall_q ? '0 : to_next;
            if (!fall_q && to_next == TO_LIMIT) begin
                error_d = 1'b1;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        end
        if (error_d) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign ps2clk_oe  = clk_oe_q;
    assign ps2data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a behavioural PS/2 device.
// Device clock is scaled to a 120-cycle period to keep runtime short.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 100;
    localparam int TMO = 50000;
    localparam int FLT = 8;
    localparam int H   = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2clk_oe, ps2data_oe;
    logic       ps2clk_line, ps2data_line;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       glitch = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       done;
        logic       chk;
    } sb_t;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
        logic       done;
    } vec_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    vec_t        vecs[4];
    int          total = 0;
    int          bad = 0;
    int          n_pulse = 0;
    logic        prev_done = 1'b0;
    logic        prev_err = 1'b0;
    logic [10:0] cap_frame = '0;

    always #5 clk = ~clk;

    assign ps2clk_line  = ~(ps2clk_oe | dev_clk_low | glitch);
    assign ps2data_line = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(FLT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .PS2Clk(ps2clk_line),
        .PS2Data(ps2data_line),
        .ps2clk_oe(ps2clk_oe),
        .ps2data_oe(ps2data_oe)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done || prev_err)
                check("pulse_width", 32'({tx_done, tx_error}), 32'd0);
            if (tx_done || tx_error) begin
                n_pulse++;
                check("pulse_excl", 32'(tx_done & tx_error), 32'd0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b",
                             tx_done, tx_error);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("outcome_done", 32'(tx_done), 32'(mon_e.done));
                    if (mon_e.chk)
                        check("frame", 32'(cap_frame),
                              32'({1'b1, mon_e.par, mon_e.data, 1'b0}));
                    check("release",
                          32'({tx_busy, ps2clk_oe, ps2data_oe}), 32'd0);
                end
            end
        end
        prev_done = tx_done;
        prev_err  = tx_error;
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~d;
        check("accept", 32'({tx_busy, ps2clk_oe}), 32'd3);
    endtask

    // Device: waits for the host request, then clocks nclk bits.
    task automatic dev_frame(input logic ack, input int nclk,
                             input logic glitch_en);
        int w;
        w = 0;
        cap_frame = '0;
        while (!(ps2clk_oe == 1'b0 && ps2data_line == 1'b0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            total++;
            bad++;
            $display("FAIL dev_request: got none expected request");
            return;
        end
        cap_frame[0] = ps2data_line;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (H / 2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            @(negedge clk);
            if (k <= 10) cap_frame[k] = ps2data_line;
            if (glitch_en && k == 4) begin
                repeat (20) @(negedge clk);
                glitch = 1'b1;
                repeat (5) @(negedge clk);
                glitch = 1'b0;
                repeat (H - 26) @(negedge clk);
            end else begin
                repeat (H - 1) @(negedge clk);
            end
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_pulse(input int n0);
        int w;
        w = 0;
        while (n_pulse == n0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        repeat (20) @(negedge clk);
        check("one_pulse", 32'(n_pulse - n0), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic ack,
                             input logic par, input logic done,
                             input logic glitch_en);
        int  n0;
        sb_t e;
        n0 = n_pulse;
        e = '{d, par, done, 1'b1};
        sb_q.push_back(e);
        start_tx(d);
        dev_frame(ack, 11, glitch_en);
        wait_pulse(n0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int   n0;
        int   cnt;
        int   first_d;
        int   k;
        logic any_busy;
        sb_t  e;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({tx_busy, tx_done, tx_error, ps2clk_oe, ps2data_oe}), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_frame(vecs[i].data, vecs[i].ack, vecs[i].par, vecs[i].done,
                      1'b0);

        // Request while busy must not be queued.
        n0 = n_pulse;
        e = '{8'hF4, 1'b0, 1'b1, 1'b1};
        sb_q.push_back(e);
        start_tx(8'hF4);
        fork
            dev_frame(1'b1, 11, 1'b0);
            begin
                repeat (400) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_pulse(n0);
        any_busy = 1'b0;
        repeat (300) begin
            @(negedge clk);
            any_busy = any_busy | tx_busy | ps2clk_oe;
        end
        check("busy_req_ignored", 32'(any_busy), 32'd0);

        // Silent device: inhibit length then watchdog expiry.
        n0 = n_pulse;
        e = '{8'h12, 1'b0, 1'b0, 1'b0};
        sb_q.push_back(e);
        start_tx(8'h12);
        cnt = 1;
        first_d = 0;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (!ps2clk_oe) break;
            cnt++;
            if (ps2data_oe && first_d == 0) first_d = cnt;
        end
        check("inhibit_len", 32'(cnt), 32'(INH + 1));
        check("data_oe_rise", 32'(first_d), 32'(INH + 1));
        check("start_bit_held", 32'(ps2data_oe), 32'd1);
        k = 0;
        while (!tx_error && k < TMO + 1000) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", 32'(k), 32'(TMO));
        @(negedge clk);
        check("timeout_released", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
        repeat (20) @(negedge clk);
        check("timeout_one_pulse", 32'(n_pulse - n0), 32'd1);

        // Reset in the middle of a frame.
        n0 = n_pulse;
        start_tx(8'h3C);
        dev_frame(1'b1, 4, 1'b0);
        check("midframe_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_midframe",
              32'({tx_busy, tx_done, tx_error, ps2clk_oe, ps2data_oe}), 32'd0);
        repeat (50) @(negedge clk);
        check("no_pulse_after_reset", 32'(n_pulse - n0), 32'd0);
        run_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);

        // Short low glitch on the clock line during the data bits.
        run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
